// File: rtl/adc_code_filter.sv
// ADC sample filter: averages windows of 2^AVG_LOG2 samples, scales each average to 0..CODE_MAX
// and only commits a new output code once it has been seen for STABLE_N consecutive windows.
module adc_code_filter #(
   parameter int ADC_W    = 12,
   parameter int CODE_MAX = 100,
   parameter int CODE_W   = 7,
   parameter int AVG_LOG2 = 2,
   parameter int STABLE_N = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              adc_valid,
   input  logic [ADC_W-1:0]  adc_data,
   output logic [CODE_W-1:0] code,
   output logic              code_valid,
   output logic              code_changed
);

   localparam int SUM_W  = ADC_W + AVG_LOG2;
   localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int MUL_W  = $clog2(CODE_MAX + 2);
   localparam int PROD_W = ADC_W + MUL_W;
   localparam logic [MUL_W-1:0] SCALE    = MUL_W'(CODE_MAX + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [3:0]       STABLE   = 4'(STABLE_N);

   typedef enum logic {PRIME = 1'b0, TRACK = 1'b1} state_t;

   logic [SUM_W-1:0]  sum_q, sum_d, sum_full_s;
   logic [CNT_W-1:0]  smp_cnt_q, smp_cnt_d;
   logic [ADC_W-1:0]  avg_s;
   logic [PROD_W-1:0] prod_s;
   logic [CODE_W-1:0] cand_q, cand_d;
   logic              cand_vld_q, cand_vld_d;
   state_t            state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d, pend_q, pend_d;
   logic [3:0]        stab_cnt_q, stab_cnt_d;
   logic              code_valid_q, code_valid_d, code_changed_q, code_changed_d;

   // Stage 1: accumulate accepted samples; the closing sample is folded in directly
   always_comb begin
      sum_full_s = sum_q + SUM_W'(adc_data);
      avg_s      = ADC_W'(sum_full_s >> AVG_LOG2);
      prod_s     = PROD_W'(avg_s) * PROD_W'(SCALE);
      sum_d      = sum_q;
      smp_cnt_d  = smp_cnt_q;
      cand_d     = cand_q;
      cand_vld_d = 1'b0;
      if (adc_valid) begin
         if (smp_cnt_q == LAST_CNT) begin
            sum_d      = '0;
            smp_cnt_d  = '0;
            cand_d     = CODE_W'(prod_s >> ADC_W);
            cand_vld_d = 1'b1;
         end else begin
            sum_d     = sum_full_s;
            smp_cnt_d = smp_cnt_q + CNT_W'(1);
         end
      end else begin
         sum_d     = sum_q;
         smp_cnt_d = smp_cnt_q;
      end
   end

   // Commit FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PRIME;
      end else begin
         state_q <= state_d;
      end
   end

   // Commit FSM next state: leave PRIME on the first candidate
   always_comb begin
      state_d = state_q;
      case (state_q)
         PRIME:   state_d = cand_vld_q ? TRACK : PRIME;
         TRACK:   state_d = TRACK;
         default: state_d = PRIME;
      endcase
   end

   // Commit FSM outputs: pend/stab_cnt track a run of identical candidates differing from code
   always_comb begin
      code_d         = code_q;
      pend_d         = pend_q;
      stab_cnt_d     = stab_cnt_q;
      code_valid_d   = cand_vld_q;
      code_changed_d = 1'b0;
      case (state_q)
         PRIME: begin
            if (cand_vld_q) begin
               code_d         = cand_q;
               pend_d         = cand_q;
               stab_cnt_d     = 4'd0;
               code_changed_d = 1'b1;
            end else begin
               code_changed_d = 1'b0;
            end
         end
         TRACK: begin
            if (!cand_vld_q) begin
               code_changed_d = 1'b0;
            end else if (cand_q == code_q) begin
               stab_cnt_d = 4'd0;
               pend_d     = cand_q;
            end else if (cand_q == pend_q) begin
               if (stab_cnt_q + 4'd1 == STABLE) begin
                  code_d         = cand_q;
                  stab_cnt_d     = 4'd0;
                  code_changed_d = 1'b1;
               end else begin
                  stab_cnt_d = stab_cnt_q + 4'd1;
               end
            end else begin
               pend_d = cand_q;
               if (STABLE == 4'd1) begin
                  code_d         = cand_q;
                  stab_cnt_d     = 4'd0;
                  code_changed_d = 1'b1;
               end else begin
                  stab_cnt_d = 4'd1;
               end
            end
         end
         default: begin
            code_valid_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q          <= '0;
         smp_cnt_q      <= '0;
         cand_q         <= '0;
         cand_vld_q     <= 1'b0;
         code_q         <= '0;
         pend_q         <= '0;
         stab_cnt_q     <= 4'd0;
         code_valid_q   <= 1'b0;
         code_changed_q <= 1'b0;
      end else begin
         sum_q          <= sum_d;
         smp_cnt_q      <= smp_cnt_d;
         cand_q         <= cand_d;
         cand_vld_q     <= cand_vld_d;
         code_q         <= code_d;
         pend_q         <= pend_d;
         stab_cnt_q     <= stab_cnt_d;
         code_valid_q   <= code_valid_d;
         code_changed_q <= code_changed_d;
      end
   end

   assign code         = code_q;
   assign code_valid   = code_valid_q;
   assign code_changed = code_changed_q;

endmodule

// File: tb/tb_adc_code_filter.sv
// Self-checking bench for adc_code_filter: directed test-plan scenarios followed by randomized
// windows, all compared cycle by cycle against a queue-based reference model.
module tb_adc_code_filter;

   localparam int WIN    = 4;
   localparam int STAB_N = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        adc_valid = 1'b0;
   logic [11:0] adc_data = 12'd0;
   logic [6:0]  code;
   logic        code_valid;
   logic        code_changed;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int pulses   = 0;

   typedef struct {int due; bit chg; int code;} ev_t;
   ev_t exp_q[$];
   int  win_q[$];
   int  hist_q[$];
   bit  primed   = 1'b0;
   int  code_m   = 0;
   int  vis_code = 0;

   adc_code_filter dut (
      .clk          (clk),
      .rst          (rst),
      .adc_valid    (adc_valid),
      .adc_data     (adc_data),
      .code         (code),
      .code_valid   (code_valid),
      .code_changed (code_changed)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   // Reference: average, scale, then commit when the last STABLE_N candidates agree and differ.
   task automatic model_edge(input logic v, input int d, input logic r);
      int  sum, cand;
      bit  chg, agree;
      if (r) begin
         win_q = {}; exp_q = {}; hist_q = {};
         primed = 1'b0; code_m = 0; vis_code = 0;
      end else if (v) begin
         win_q.push_back(d);
         if (win_q.size() == WIN) begin
            sum = 0;
            foreach (win_q[i]) sum += win_q[i];
            cand = ((sum / WIN) * 101) / 4096;
            win_q = {};
            chg = 1'b0;
            hist_q.push_back(cand);
            if (!primed) begin
               primed = 1'b1;
               code_m = cand;
               chg    = 1'b1;
            end else if (cand != code_m && hist_q.size() >= STAB_N) begin
               agree = 1'b1;
               for (int k = hist_q.size() - STAB_N; k < hist_q.size(); k++)
                  if (hist_q[k] != cand) agree = 1'b0;
               if (agree) begin
                  code_m = cand;
                  chg    = 1'b1;
               end
            end
            exp_q.push_back('{due: cyc + 2, chg: chg, code: code_m});
         end
      end
   endtask

   task automatic check_outputs();
      bit ev, ec;
      ev = 1'b0; ec = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         ev = 1'b1;
         ec = exp_q[0].chg;
         vis_code = exp_q[0].code;
         void'(exp_q.pop_front());
      end
      if (code_valid === 1'b1) pulses++;
      check_eq("code_valid", 32'(code_valid), 32'(ev));
      check_eq("code_changed", 32'(code_changed), 32'(ec));
      check_eq("code", 32'(code), 32'(vis_code));
   endtask

   task automatic tick(input logic v, input int d, input logic r);
      adc_valid = v;
      adc_data  = 12'(d);
      rst       = r;
      model_edge(v, d, r);
      @(posedge clk);
      cyc++;
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0);
   endtask

   task automatic send_win(input int d, input int gap);
      for (int i = 0; i < WIN; i++) begin
         tick(1'b1, d, 1'b0);
         idle(gap);
      end
   endtask

   task automatic do_reset();
      tick(1'b0, 0, 1'b1);
      tick(1'b0, 0, 1'b1);
   endtask

   initial begin
      int lvl, hold, smp, gap;
      // events due cyc+2 are checked at the second edge after the closing sample
      do_reset();
      check_eq("reset_code", 32'(code), 32'd0);

      // prime commit
      send_win(4095, 0);
      idle(3);
      check_eq("prime_code", 32'(code), 32'd100);

      // boundary scaling
      do_reset();
      send_win(0, 0);
      for (int w = 0; w < 3; w++) send_win(41, 0);
      idle(3);
      check_eq("scale_41", 32'(code), 32'd1);
      for (int w = 0; w < 3; w++) send_win(40, 0);
      idle(3);
      check_eq("scale_40", 32'(code), 32'd0);

      // stability
      do_reset();
      send_win(4095, 0);
      idle(3);
      pulses = 0;
      for (int w = 0; w < 3; w++) send_win(2048, 1);
      idle(3);
      check_eq("stab_pulses", 32'(pulses), 32'd3);
      check_eq("stab_code", 32'(code), 32'd50);

      // counter restart: 60,60,70,70,70
      send_win(2434, 0); send_win(2434, 0);
      send_win(2839, 0); send_win(2839, 0);
      idle(3);
      check_eq("restart_hold", 32'(code), 32'd50);
      send_win(2839, 0);
      idle(3);
      check_eq("restart_code", 32'(code), 32'd70);

      // gapped input
      do_reset();
      send_win(0, 0);
      idle(3);
      pulses = 0;
      tick(1'b1, 4095, 1'b0);
      tick(1'b1, 4095, 1'b0);
      idle(3);
      tick(1'b1, 4095, 1'b0);
      idle(7);
      tick(1'b1, 4095, 1'b0);
      idle(4);
      check_eq("gap_pulses", 32'(pulses), 32'd1);
      check_eq("gap_code", 32'(code), 32'd0);

      // reset mid-window
      do_reset();
      tick(1'b1, 500, 1'b0);
      tick(1'b1, 500, 1'b0);
      tick(1'b1, 3000, 1'b1);
      pulses = 0;
      send_win(1024, 0);
      idle(4);
      check_eq("midrst_pulses", 32'(pulses), 32'd1);
      check_eq("midrst_code", 32'(code), 32'd25);

      // randomized windows with jitter, gaps and occasional reset
      for (int w = 0; w < 250; w++) begin
         if ($urandom_range(0, 59) == 0) do_reset();
         lvl  = $urandom_range(0, 4095);
         hold = $urandom_range(1, 5);
         for (int h = 0; h < hold; h++) begin
            for (int s = 0; s < WIN; s++) begin
               smp = lvl + $urandom_range(0, 60) - 30;
               if (smp < 0) smp = 0;
               if (smp > 4095) smp = 4095;
               gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
               tick(1'b1, smp, 1'b0);
               idle(gap);
            end
         end
      end
      idle(4);
      check_eq("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
